// File: rtl/afpm_operand_tx.sv
// Byte-serial operand transmitter for the logarithmic FP16 multiplier.
// Buffers (A, B) pairs in a small FIFO and sends each as a low-byte then high-byte frame.
module afpm_operand_tx #(
   parameter int unsigned HOLD_CYCLES = 3,
   parameter int unsigned GAP_CYCLES  = 6,
   parameter int unsigned DEPTH       = 2
) (
   input  logic                   clk,
   input  logic                   rst_n,
   input  logic                   in_valid,
   output logic                   in_ready,
   input  logic [15:0]            in_a,
   input  logic [15:0]            in_b,
   output logic [7:0]             lane_a,
   output logic [7:0]             lane_b,
   output logic                   lane_phase,
   output logic                   lane_active,
   output logic                   frame_start,
   output logic                   frame_done,
   output logic [$clog2(DEPTH):0] level
);

   localparam int unsigned PtrW   = $clog2(DEPTH);
   localparam int unsigned LvlW   = PtrW + 1;
   localparam int unsigned CntMax = (HOLD_CYCLES > GAP_CYCLES) ? HOLD_CYCLES : GAP_CYCLES;
   localparam int unsigned CntW   = (CntMax > 1) ? $clog2(CntMax) : 1;

   localparam logic [CntW-1:0] HoldLoad = CntW'(HOLD_CYCLES - 1);
   localparam logic [CntW-1:0] GapLoad  = CntW'((GAP_CYCLES > 0) ? GAP_CYCLES - 1 : 0);
   localparam logic [LvlW-1:0] Full     = LvlW'(DEPTH);

   typedef enum logic [1:0] {StIdle, StLow, StHigh, StGap} state_e;

   state_e          state;
   logic [CntW-1:0] cnt;
   logic [31:0]     frame;
   logic [31:0]     mem [DEPTH];
   logic [PtrW-1:0] wr_ptr;
   logic [PtrW-1:0] rd_ptr;
   logic [31:0]     head;
   logic            push;
   logic            load;

   assign in_ready = (level != Full);
   assign push     = in_valid && in_ready;
   assign head     = mem[rd_ptr];

   // A pop happens exactly when the FSM starts a new frame.
   always_comb begin
      load = 1'b0;
      if (level != '0) begin
         unique case (state)
            StIdle:  load = 1'b1;
            StHigh:  load = (cnt == '0) && (GAP_CYCLES == 0);
            StGap:   load = (cnt == '0);
            default: load = 1'b0;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (push) begin
         mem[wr_ptr] <= {in_a, in_b};
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         level  <= '0;
      end else begin
         if (push) begin
            wr_ptr <= wr_ptr + PtrW'(1);
         end
         if (load) begin
            rd_ptr <= rd_ptr + PtrW'(1);
         end
         if (push && !load) begin
            level <= level + LvlW'(1);
         end else if (load && !push) begin
            level <= level - LvlW'(1);
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state       <= StIdle;
         cnt         <= '0;
         frame       <= '0;
         lane_a      <= '0;
         lane_b      <= '0;
         lane_phase  <= 1'b0;
         lane_active <= 1'b0;
         frame_start <= 1'b0;
         frame_done  <= 1'b0;
      end else begin
         frame_start <= 1'b0;
         frame_done  <= 1'b0;
         if (load) begin
            // Lanes are driven from the popped word now and from the frame register later.
            state       <= StLow;
            cnt         <= HoldLoad;
            frame       <= head;
            lane_a      <= head[23:16];
            lane_b      <= head[7:0];
            lane_phase  <= 1'b0;
            lane_active <= 1'b1;
            frame_start <= 1'b1;
         end else begin
            unique case (state)
               StIdle: begin
                  cnt <= '0;
               end
               StLow: begin
                  if (cnt == '0) begin
                     state      <= StHigh;
                     cnt        <= HoldLoad;
                     lane_a     <= frame[31:24];
                     lane_b     <= frame[15:8];
                     lane_phase <= 1'b1;
                     frame_done <= (HOLD_CYCLES == 1);
                  end else begin
                     cnt <= cnt - CntW'(1);
                  end
               end
               StHigh: begin
                  if (cnt == '0) begin
                     lane_a      <= '0;
                     lane_b      <= '0;
                     lane_phase  <= 1'b0;
                     lane_active <= 1'b0;
                     if (GAP_CYCLES > 0) begin
                        state <= StGap;
                        cnt   <= GapLoad;
                     end else begin
                        state <= StIdle;
                     end
                  end else begin
                     cnt        <= cnt - CntW'(1);
                     frame_done <= (cnt == CntW'(1));
                  end
               end
               StGap: begin
                  if (cnt == '0) begin
                     state <= StIdle;
                  end else begin
                     cnt <= cnt - CntW'(1);
                  end
               end
               default: state <= StIdle;
            endcase
         end
      end
   end

endmodule

// File: tb/tb_afpm_operand_tx.sv
// Bench for afpm_operand_tx: a default instance and a HOLD=1/GAP=0 instance, each checked
// every cycle against a frame-offset model, plus hand-computed directed expectations.
module tb_afpm_operand_tx;

   localparam int D = 2;

   function automatic int hold_of(int k);
      return (k == 0) ? 3 : 1;
   endfunction

   function automatic int gap_of(int k);
      return (k == 0) ? 6 : 0;
   endfunction

   logic        clk   = 1'b0;
   logic        rst_n = 1'b0;
   logic        iv  [2];
   logic [15:0] ia  [2];
   logic [15:0] ib  [2];
   logic        rdy [2];
   logic [7:0]  la  [2];
   logic [7:0]  lb  [2];
   logic        ph  [2];
   logic        act [2];
   logic        fs  [2];
   logic        fd  [2];
   logic [1:0]  lvl [2];

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   afpm_operand_tx #(.HOLD_CYCLES(3), .GAP_CYCLES(6), .DEPTH(D)) dut0 (
      .clk(clk), .rst_n(rst_n), .in_valid(iv[0]), .in_ready(rdy[0]), .in_a(ia[0]),
      .in_b(ib[0]), .lane_a(la[0]), .lane_b(lb[0]), .lane_phase(ph[0]),
      .lane_active(act[0]), .frame_start(fs[0]), .frame_done(fd[0]), .level(lvl[0])
   );

   afpm_operand_tx #(.HOLD_CYCLES(1), .GAP_CYCLES(0), .DEPTH(D)) dut1 (
      .clk(clk), .rst_n(rst_n), .in_valid(iv[1]), .in_ready(rdy[1]), .in_a(ia[1]),
      .in_b(ib[1]), .lane_a(la[1]), .lane_b(lb[1]), .lane_phase(ph[1]),
      .lane_active(act[1]), .frame_start(fs[1]), .frame_done(fd[1]), .level(lvl[1])
   );

   // Model: list of accepted pairs plus the offset of the visible cycle within the current frame.
   logic [31:0] mlist [2][D];
   int          mcnt  [2] = '{0, 0};
   int          mpos  [2] = '{-1, -1};
   logic [31:0] mcur  [2];

   always @(posedge clk or negedge rst_n) begin : model
      bit acc;
      int flen;
      if (!rst_n) begin
         for (int k = 0; k < 2; k++) begin
            mcnt[k] = 0;
            mpos[k] = -1;
         end
      end else begin
         for (int k = 0; k < 2; k++) begin
            flen = 2 * hold_of(k) + gap_of(k);
            acc  = iv[k] && (mcnt[k] < D);
            if (mpos[k] >= 0) begin
               mpos[k]++;
               if (mpos[k] == flen) mpos[k] = -1;
            end
            if (mpos[k] < 0 && mcnt[k] > 0) begin
               mcur[k] = mlist[k][0];
               for (int i = 0; i < D - 1; i++) mlist[k][i] = mlist[k][i+1];
               mcnt[k]--;
               mpos[k] = 0;
            end
            if (acc) begin
               mlist[k][mcnt[k]] = {ia[k], ib[k]};
               mcnt[k]++;
            end
         end
      end
   end

   function automatic logic [22:0] expect_of(int k);
      int         h = hold_of(k);
      int         p = mpos[k];
      logic [7:0] ea = 8'h00;
      logic [7:0] eb = 8'h00;
      if (p >= 0 && p < h) begin
         ea = mcur[k][23:16];
         eb = mcur[k][7:0];
      end else if (p >= h && p < 2 * h) begin
         ea = mcur[k][31:24];
         eb = mcur[k][15:8];
      end
      return {ea, eb, (p >= h && p < 2 * h), (p >= 0 && p < 2 * h), (p == 0),
              (p == 2 * h - 1), 2'(mcnt[k]), (mcnt[k] < D)};
   endfunction

   always @(negedge clk) begin : compare
      logic [22:0] e;
      logic [22:0] g;
      for (int k = 0; k < 2; k++) begin
         e = expect_of(k);
         g = {la[k], lb[k], ph[k], act[k], fs[k], fd[k], lvl[k], rdy[k]};
         checks++;
         if (g !== e) begin
            errors++;
            $display("FAIL cycle_dut%0d t=%0t got=%h want=%h", k, $time, g, e);
         end
      end
   end

   // Frame pulse bookkeeping for dut0.
   int cyc  = 0;
   int nfs0 = 0;
   int nfd0 = 0;
   int fs_cyc [8];

   always @(posedge clk) cyc++;

   always @(negedge clk) begin
      if (fs[0] === 1'b1) begin
         if (nfs0 < 8) fs_cyc[nfs0] = cyc;
         nfs0++;
      end
      if (fd[0] === 1'b1) nfd0++;
   end

   task automatic chk(string name, logic [31:0] got, logic [31:0] want);
      checks++;
      if (got !== want) begin
         errors++;
         $display("FAIL %s got=%h want=%h", name, got, want);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic push(int k, logic [15:0] a, logic [15:0] b);
      bit ok = 1'b0;
      iv[k] = 1'b1;
      ia[k] = a;
      ib[k] = b;
      for (int i = 0; i < 100 && !ok; i++) begin
         @(negedge clk);
         ok = rdy[k];
      end
      if (!ok) begin
         checks++;
         errors++;
         $display("FAIL push_timeout dut%0d got=not_ready want=ready", k);
      end
      step();
      iv[k] = 1'b0;
   endtask

   initial begin
      bit seen;
      iv = '{1'b1, 1'b1};
      ia = '{16'hDEAD, 16'hBEEF};
      ib = '{16'h1357, 16'h2468};

      // Reset held with in_valid high.
      repeat (2) @(negedge clk);
      chk("rst_lane_a", la[0], 0);
      chk("rst_lane_b", lb[0], 0);
      chk("rst_level", lvl[0], 0);
      chk("rst_ready", rdy[0], 1);
      chk("rst_active", act[0], 0);
      chk("rst_pulses", {fs[0], fd[0], ph[0]}, 0);
      chk("rst_level_dut1", lvl[1], 0);
      step();
      iv    = '{1'b0, 1'b0};
      rst_n = 1'b1;
      repeat (2) step();

      // Single frame.
      push(0, 16'h3E00, 16'h4200);
      step();
      @(negedge clk);
      chk("sf_start", fs[0], 1);
      chk("sf_low", {la[0], lb[0]}, 16'h0000);
      chk("sf_low_phase", ph[0], 0);
      chk("sf_low_active", act[0], 1);
      repeat (3) @(negedge clk);
      chk("sf_high", {la[0], lb[0]}, 16'h3E42);
      chk("sf_high_phase", ph[0], 1);
      chk("sf_high_done_early", fd[0], 0);
      repeat (2) @(negedge clk);
      chk("sf_done", fd[0], 1);
      @(negedge clk);
      chk("sf_gap_active", act[0], 0);
      chk("sf_gap_lanes", {la[0], lb[0]}, 16'h0000);
      repeat (8) @(negedge clk);
      step();

      // Back-to-back frames, then a push held across the pop edge of a full FIFO.
      nfs0 = 0;
      nfd0 = 0;
      push(0, 16'h0101, 16'h0101);
      push(0, 16'h3E00, 16'h4200);
      push(0, 16'h3C00, 16'hC000);
      @(negedge clk);
      chk("b2b_full_ready", rdy[0], 0);
      chk("b2b_full_level", lvl[0], 2);
      step();
      push(0, 16'h4400, 16'h4800);
      @(negedge clk);
      chk("full_refill_level", lvl[0], 2);
      chk("full_push_next", cyc - fs_cyc[1], 1);
      repeat (60) @(negedge clk);
      chk("b2b_starts", nfs0, 4);
      chk("b2b_dones", nfd0, 4);
      chk("b2b_spacing1", fs_cyc[1] - fs_cyc[0], 12);
      chk("b2b_spacing2", fs_cyc[2] - fs_cyc[1], 12);
      chk("b2b_spacing3", fs_cyc[3] - fs_cyc[2], 12);
      chk("b2b_drained", lvl[0], 0);
      step();

      // HOLD=1, GAP=0 instance with two queued pairs.
      push(1, 16'h1234, 16'h5678);
      push(1, 16'hABCD, 16'hEF01);
      @(negedge clk);
      chk("h1_low1", {la[1], lb[1], fs[1], act[1]}, {16'h3478, 2'b11});
      @(negedge clk);
      chk("h1_high1", {la[1], lb[1], fd[1], act[1], fs[1]}, {16'h1256, 3'b110});
      @(negedge clk);
      chk("h1_low2", {la[1], lb[1], fs[1], act[1]}, {16'hCD01, 2'b11});
      @(negedge clk);
      chk("h1_high2", {la[1], lb[1], fd[1], act[1]}, {16'hABEF, 2'b11});
      @(negedge clk);
      chk("h1_idle", {la[1], lb[1], act[1]}, 17'h0);
      step();

      // Reset during the HIGH phase with another pair queued.
      push(0, 16'h1111, 16'h2222);
      push(0, 16'h3333, 16'h4444);
      seen = 1'b0;
      for (int i = 0; i < 50 && !seen; i++) begin
         @(negedge clk);
         seen = ph[0];
      end
      chk("mid_high_reached", seen, 1);
      #2;
      rst_n = 1'b0;
      nfs0  = 0;
      nfd0  = 0;
      #1;
      chk("mid_rst_lanes", {la[0], lb[0]}, 16'h0000);
      chk("mid_rst_flags", {ph[0], act[0], fs[0], fd[0]}, 4'h0);
      chk("mid_rst_level", lvl[0], 0);
      chk("mid_rst_ready", rdy[0], 1);
      repeat (2) @(posedge clk);
      #1;
      rst_n = 1'b1;
      repeat (20) @(negedge clk);
      chk("mid_rst_no_done", nfd0, 0);
      chk("mid_rst_no_start", nfs0, 0);
      chk("mid_rst_idle", act[0], 0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
